ram_sp_be: RTL and testbench

- Parametrised single-port synchronous RAM; successor to the 8-bit tristate single-port RAM.
- Separate write and read data buses replace the bidirectional bus.
- Adds per-byte write enables, a read-valid strobe, a registered read path, and a hardware zero-fill engine (after reset and on request).
- Sits between bus masters/CPU datapath and storage wherever the codebase needs scratch memory with a known initial state.

---
 rtl/ram_sp_be.sv | 145 ++++++++++++++
 tb/tb_ram_sp_be.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_be.sv
// ram_sp_be: parametrised single-port synchronous RAM with per-byte write enables,
// a registered read path and a hardware zero-fill engine.
//
// After reset, and whenever clr is accepted in idle, the engine walks every
// address and writes zero. busy is high for exactly DEPTH cycles while this runs,
// and all accesses are ignored during that time.
//
// Optional build macro RAM_SP_OUTREG_EN: adds a second output register stage,
// so read latency becomes 2 cycles and rvalid moves with the data.
//
// Ports:
//   clk    in   single clock, rising edge
//   rst    in   synchronous active-high reset
//   cs     in   chip select (accepted when busy=0)
//   we     in   1=write, 0=read
//   be     in   per-byte write enables (ignored on reads)
//   addr   in   word address
//   wdata  in   write data
//   clr    in   zero-fill request (sampled only when busy=0; wins over cs)
//   rdata  out  read data, held until the next read completes
//   rvalid out  one-cycle strobe marking a fresh rdata
//   busy   out  zero-fill in progress
module ram_sp_be #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_BYTES  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  we,
    input  logic [NUM_BYTES-1:0]  be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {StFill, StIdle} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic acc_ok;
    logic wr_en;
    logic rd_en;
    logic fill_en;

    // clr takes priority over a same-cycle access; nothing is accepted under reset
    assign acc_ok  = (state_q == StIdle) & ~rst & cs & ~clr;
    assign wr_en   = acc_ok & we;
    assign rd_en   = acc_ok & ~we;
    assign fill_en = (state_q == StFill) & ~rst;

    // Control FSM: fill walker and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            cnt_q   <= '0;
            busy    <= 1'b1;
        end else begin
            unique case (state_q)
                StFill: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StIdle: begin
                    if (clr) begin
                        state_q <= StFill;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StFill;
                    cnt_q   <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: no reset so it maps onto RAM; the fill pass initialises it
    always_ff @(posedge clk) begin
        if (fill_en) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // First read stage: data held between reads
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= mem[addr];
            end
        end
    end

`ifdef RAM_SP_OUTREG_EN
    // Second stage: a read already in the pipe completes even if clr is taken
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
                out_data_q <= rd_data_q;
            end
        end
    end

    assign rdata  = out_data_q;
    assign rvalid = out_valid_q;
`else
    assign rdata  = rd_data_q;
    assign rvalid = rd_valid_q;
`endif

endmodule

// File: tb/tb_ram_sp_be.sv
// Self-checking bench for ram_sp_be (DATA_WIDTH=16, ADDR_WIDTH=4).
module tb_ram_sp_be;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef RAM_SP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    be = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          clr = 1'b0;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    int            got_cyc [$];

    ram_sp_be #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cs    (cs),
        .we    (we),
        .be    (be),
        .addr  (addr),
        .wdata (wdata),
        .clr   (clr),
        .rdata (rdata),
        .rvalid(rvalid),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Response monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            got_q.push_back(rdata);
            got_cyc.push_back(cyc_n);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus; returns at the negedge after the edge that used it
    task automatic drive(input logic c, input logic w, input logic [1:0] b,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic k);
        cs = c; we = w; be = b; addr = a; wdata = d; clr = k;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; clr = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
        logic [DW-1:0] mask;
        mask = (b[0] ? 16'h00FF : 16'h0000) | (b[1] ? 16'hFF00 : 16'h0000);
        model[a] = (model[a] & ~mask) | (d & mask);
        drive(1'b1, 1'b1, b, a, d, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        exp_q.push_back(model[a]);
        drive(1'b1, 1'b0, 2'b00, a, 16'h0000, 1'b0);
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic drain_and_flush();
        repeat (LAT + 3) @(negedge clk);
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rdata !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata: got %h, expected 0000", rdata);
        end
        checks++;
        if (rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid: got %b, expected 0", rvalid);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got %b, expected 1", busy);
        end
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != DEPTH) begin
            errors++; $display("FAIL reset_fill_len: busy cycles %0d, expected %0d", n, DEPTH);
        end
        zero_model();
        drain_and_flush();
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (got_q.size() != DEPTH) begin
            errors++;
            $display("FAIL reset_read_count: got %0d pulses, expected %0d", got_q.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_read_%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        drain_and_flush();
    endtask

    task automatic test_byte_enables();
        wr(5, 16'hABCD, 2'b11);
        wr(5, 16'h1234, 2'b01);
        rd(5);
        for (int k = 1; k < LAT; k++) begin
            checks++;
            if (rvalid !== 1'b0) begin
                errors++; $display("FAIL be_early_rvalid: got %b, expected 0", rvalid);
            end
            @(negedge clk);
        end
        checks++;
        if (rvalid !== 1'b1 || rdata !== model[5]) begin
            errors++;
            $display("FAIL be_read: got rvalid=%b rdata=%h, expected rvalid=1 rdata=%h",
                     rvalid, rdata, model[5]);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            errors++; $display("FAIL be_pulse_width: got rvalid=%b, expected 0", rvalid);
        end
        drain_and_flush();
    endtask

    task automatic test_read_hold();
        rd(5);
        repeat (LAT - 1) @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rvalid !== 1'b0 || rdata !== 16'hAB34) begin
                errors++;
                $display("FAIL hold_%0d: got rvalid=%b rdata=%h, expected rvalid=0 rdata=ab34",
                         k, rvalid, rdata);
            end
            @(negedge clk);
        end
        drain_and_flush();
    endtask

    task automatic test_back_to_back();
        wr(3, 16'hBEEF, 2'b11);
        rd(3);
        rd(4);
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d pulses, expected 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 16'hBEEF || got_q[1] !== exp_q[1]) begin
                errors++;
                $display("FAIL b2b_data: got %h %h, expected beef %h", got_q[0], got_q[1], exp_q[1]);
            end
            checks++;
            if (got_cyc[1] != got_cyc[0] + 1) begin
                errors++;
                $display("FAIL b2b_adjacent: pulse gap %0d, expected 1", got_cyc[1] - got_cyc[0]);
            end
        end
        drain_and_flush();
    endtask

    task automatic test_clear_priority();
        int n;
        wr(7, 16'h5555, 2'b11);
        rd(7);
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 16'h5555) begin
            errors++;
            $display("FAIL clr_preload: got %0d pulses first=%h, expected 1 pulse 5555",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
        drain_and_flush();
        drive(1'b1, 1'b1, 2'b11, 7, 16'hFFFF, 1'b1);
        zero_model();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != DEPTH) begin
            errors++; $display("FAIL clr_fill_len: busy cycles %0d, expected %0d", n, DEPTH);
        end
        checks++;
        if (got_q.size() != 0) begin
            errors++; $display("FAIL clr_no_rvalid: got %0d pulses, expected 0", got_q.size());
        end
        drain_and_flush();
        rd(7);
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 16'h0000) begin
            errors++;
            $display("FAIL clr_cleared: got %0d pulses first=%h, expected 1 pulse 0000",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
        drain_and_flush();
    endtask

    task automatic test_reset_mid_fill();
        int n;
        drive(1'b0, 1'b0, 2'b00, 0, 16'h0000, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        zero_model();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            // Accesses attempted while busy must be ignored
            cs = (n == 3 || n == 5 || n == DEPTH);
            we = (n == 3);
            be = 2'b11;
            addr = 2;
            wdata = 16'h1111;
            @(negedge clk);
        end
        cs = 1'b0;
        we = 1'b0;
        checks++;
        if (n != DEPTH) begin
            errors++; $display("FAIL rstfill_len: busy cycles %0d, expected %0d", n, DEPTH);
        end
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (got_q.size() != 0) begin
            errors++; $display("FAIL rstfill_no_rvalid: got %0d pulses, expected 0", got_q.size());
        end
        drain_and_flush();
        rd(2);
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 16'h0000) begin
            errors++;
            $display("FAIL rstfill_addr2: got %0d pulses first=%h, expected 1 pulse 0000",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
        drain_and_flush();
    endtask

    task automatic test_random();
        int n;
        for (int op = 0; op < 400; op++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 2) begin
                drive(1'b0, 1'b0, 2'b00, 0, 16'h0000, 1'b1);
                zero_model();
                n = 0;
                while (busy === 1'b1 && n < 100) begin
                    n++;
                    @(negedge clk);
                end
                if (n >= 100) begin
                    checks++; errors++;
                    $display("FAIL rand_fill_timeout: busy cycles %0d, expected %0d", n, DEPTH);
                end
            end else if (sel < 50) begin
                wr(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), 2'($urandom_range(0, 3)));
            end else if (sel < 90) begin
                rd(AW'($urandom_range(0, DEPTH - 1)));
            end else begin
                @(negedge clk);
            end
        end
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_read_%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        drain_and_flush();
    endtask

    initial begin
        test_reset();
        test_byte_enables();
        test_read_hold();
        test_back_to_back();
        test_clear_priority();
        test_reset_mid_fill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
